// File: rtl/x_uart_cmd_if.sv
// rtl/x_uart_cmd_if.sv - byte-command bus between UART, register file and command decoder
//
// Purpose: bundles the UART receive strobe, register read/write strobes and the
// UART transmit handshake of x_uart_cmd into one interface.
// Ports (as seen by the decoder, modport slave):
//   i_valid, i_data     received byte strobe and byte
//   o_wr, o_rd          one-cycle register write / read strobes
//   o_addr, o_wdata     register address and write data
//   i_rdata             register read data, valid in the o_rd cycle
//   o_tx_valid, o_tx_data, i_tx_ready   response byte handshake
//   o_err               one-cycle error strobe
// The master modport is the environment view (UART + register file).
interface x_uart_cmd_if;
   logic       i_valid;
   logic [7:0] i_data;
   logic       o_wr;
   logic       o_rd;
   logic [3:0] o_addr;
   logic [7:0] o_wdata;
   logic [7:0] i_rdata;
   logic       o_tx_valid;
   logic [7:0] o_tx_data;
   logic       i_tx_ready;
   logic       o_err;

   modport slave (
      input  i_valid, i_data, i_rdata, i_tx_ready,
      output o_wr, o_rd, o_addr, o_wdata, o_tx_valid, o_tx_data, o_err
   );

   modport master (
      output i_valid, i_data, i_rdata, i_tx_ready,
      input  o_wr, o_rd, o_addr, o_wdata, o_tx_valid, o_tx_data, o_err
   );
endinterface

// File: rtl/x_uart_cmd.sv
// rtl/x_uart_cmd.sv - UART byte-command decoder driving a 16-entry register file
//
// Purpose: decodes command bytes (bit7 write/read, bits6:4 reserved zero,
// bits3:0 address). A write takes a second byte as data; a read fetches the
// register and returns it as one response byte over the transmit handshake.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    x_uart_cmd_if.slave, see the interface file for its signals
// Parameter:
//   p_timeout  maximum idle cycles allowed between the two bytes of a write
module x_uart_cmd #(
   parameter int p_timeout = 2048
) (
   input  logic          i_clk,
   input  logic          i_rst,
   x_uart_cmd_if.slave   bus
);

   localparam int CW = $clog2(p_timeout + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(p_timeout - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_RD,
      S_RESP
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          wr_q;
   logic          rd_q;
   logic          err_q;
   logic [3:0]    addr_q;
   logic [7:0]    wdata_q;
   logic          tx_valid_q;
   logic [7:0]    tx_data_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= 4'h0;
         wdata_q    <= 8'h00;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         // strobes are single-cycle by construction: cleared every cycle unless re-set below
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.i_valid) begin
                  if (bus.i_data[6:4] != 3'b000) begin
                     err_q <= 1'b1;
                  end else begin
                     addr_q <= bus.i_data[3:0];
                     if (bus.i_data[7]) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                     end else begin
                        state_q <= S_RD;
                        rd_q    <= 1'b1;
                     end
                  end
               end
            end
            S_DATA: begin
               if (bus.i_valid) begin
                  wr_q    <= 1'b1;
                  wdata_q <= bus.i_data;
                  state_q <= S_IDLE;
               end else if (cnt_q == LAST_CNT) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  // leaving at LAST_CNT keeps the count from ever passing it, so it cannot wrap
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RD: begin
               // i_rdata is valid combinationally while o_rd is high, i.e. this cycle
               tx_data_q  <= bus.i_rdata;
               tx_valid_q <= 1'b1;
               state_q    <= S_RESP;
               if (bus.i_valid) begin
                  err_q <= 1'b1;
               end
            end
            S_RESP: begin
               if (bus.i_valid) begin
                  err_q <= 1'b1;
               end
               if (bus.i_tx_ready) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_wr       = wr_q;
   assign bus.o_rd       = rd_q;
   assign bus.o_err      = err_q;
   assign bus.o_addr     = addr_q;
   assign bus.o_wdata    = wdata_q;
   assign bus.o_tx_valid = tx_valid_q;
   assign bus.o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_x_uart_cmd.sv
// tb/tb_x_uart_cmd.sv - self-checking bench for x_uart_cmd
module tb_x_uart_cmd;

   localparam int T = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   x_uart_cmd_if bus ();

   x_uart_cmd #(.p_timeout(T)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [7:0] rdata;
      logic       rdy;
      logic       wr;
      logic       rd;
      logic       err;
      logic       txv;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] txd;
   } vec_t;

   vec_t vecs[$];

   // reference model: expected outputs after the next clock edge
   bit       m_wr, m_rd, m_err, m_txv;
   bit [3:0] m_addr;
   bit [7:0] m_wdata, m_txd;
   int       m_wait_addr;
   int       m_idle;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int v, input int d, input int rdata, input int rdy,
                      input int wr, input int rd, input int err, input int txv,
                      input int addr, input int wdata, input int txd);
      vec_t x;
      x.v = v[0]; x.d = d[7:0]; x.rdata = rdata[7:0]; x.rdy = rdy[0];
      x.wr = wr[0]; x.rd = rd[0]; x.err = err[0]; x.txv = txv[0];
      x.addr = addr[3:0]; x.wdata = wdata[7:0]; x.txd = txd[7:0];
      vecs.push_back(x);
   endtask

   task automatic drive_cycle(input logic v, input logic [7:0] d, input logic [7:0] rdata, input logic rdy);
      bus.i_valid    = v;
      bus.i_data     = d;
      bus.i_rdata    = rdata;
      bus.i_tx_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string name, input logic wr, input logic rd, input logic err,
                             input logic txv, input logic [3:0] addr, input logic [7:0] wdata,
                             input logic [7:0] txd);
      check({name, ".flags"}, {28'h0, bus.o_wr, bus.o_rd, bus.o_err, bus.o_tx_valid},
            {28'h0, wr, rd, err, txv});
      if (wr || rd) check({name, ".addr"}, {28'h0, bus.o_addr}, {28'h0, addr});
      if (wr) check({name, ".wdata"}, {24'h0, bus.o_wdata}, {24'h0, wdata});
      if (txv) check({name, ".txdata"}, {24'h0, bus.o_tx_data}, {24'h0, txd});
   endtask

   task automatic check_reset_values(input string name);
      check({name, ".flags"}, {28'h0, bus.o_wr, bus.o_rd, bus.o_err, bus.o_tx_valid}, 32'h0);
      check({name, ".addr"}, {28'h0, bus.o_addr}, 32'h0);
      check({name, ".wdata"}, {24'h0, bus.o_wdata}, 32'h0);
      check({name, ".txdata"}, {24'h0, bus.o_tx_data}, 32'h0);
   endtask

   task automatic model_step(input bit v, input bit [7:0] d, input bit [7:0] rdata, input bit rdy);
      bit nw, nr, ne, ntxv;
      nw = 1'b0; nr = 1'b0; ne = 1'b0; ntxv = m_txv;
      if (m_rd) begin
         // register data is fetched in the read-strobe cycle and becomes the response
         m_txd = rdata;
         ntxv  = 1'b1;
         ne    = v;
      end else if (m_txv) begin
         ne = v;
         if (rdy) ntxv = 1'b0;
      end else if (m_wait_addr >= 0) begin
         if (v) begin
            nw          = 1'b1;
            m_addr      = m_wait_addr[3:0];
            m_wdata     = d;
            m_wait_addr = -1;
         end else if (m_idle == T - 1) begin
            ne          = 1'b1;
            m_wait_addr = -1;
         end else begin
            m_idle++;
         end
      end else if (v) begin
         if (d[6:4] != 3'b000) begin
            ne = 1'b1;
         end else begin
            m_addr = d[3:0];
            if (d[7]) begin
               m_wait_addr = int'(d[3:0]);
               m_idle      = 0;
            end else begin
               nr = 1'b1;
            end
         end
      end
      m_wr = nw; m_rd = nr; m_err = ne; m_txv = ntxv;
   endtask

   initial begin
      bus.i_valid    = 1'b0;
      bus.i_data     = 8'h00;
      bus.i_rdata    = 8'h00;
      bus.i_tx_ready = 1'b0;
      rst            = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);

      // table: inputs for one cycle, outputs expected after that cycle's edge
      add(1, 'h83, 0, 0,     0, 0, 0, 0,  0, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0,  0, 0, 0);
      add(1, 'h5A, 0, 0,     1, 0, 0, 0,  3, 'h5A, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0,  0, 0, 0);
      add(1, 'h95, 0, 0,     0, 0, 1, 0,  0, 0, 0);
      add(1, 'h81, 0, 0,     0, 0, 0, 0,  0, 0, 0);
      add(1, 'h11, 0, 0,     1, 0, 0, 0,  1, 'h11, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0,  0, 0, 0);
      add(1, 'h07, 0, 0,     0, 1, 0, 0,  7, 0, 0);
      add(0, 0, 'hC3, 0,     0, 0, 0, 1,  0, 0, 'hC3);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'hC3);
      add(0, 0, 0, 1,        0, 0, 0, 0,  0, 0, 0);
      add(1, 'h04, 0, 0,     0, 1, 0, 0,  4, 0, 0);
      add(0, 0, 'h9C, 0,     0, 0, 0, 1,  0, 0, 'h9C);
      add(1, 'hFF, 0, 0,     0, 0, 1, 1,  0, 0, 'h9C);
      add(0, 0, 0, 1,        0, 0, 0, 0,  0, 0, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0,  0, 0, 0);
      add(1, 'h0A, 0, 0,     0, 1, 0, 0,  'hA, 0, 0);
      add(0, 0, 'h66, 0,     0, 0, 0, 1,  0, 0, 'h66);
      add(1, 'h8F, 0, 1,     0, 0, 1, 0,  0, 0, 0);
      add(1, 'h03, 0, 0,     0, 1, 0, 0,  3, 0, 0);
      add(0, 0, 'h11, 0,     0, 0, 0, 1,  0, 0, 'h11);
      add(0, 0, 0, 1,        0, 0, 0, 0,  0, 0, 0);
      add(1, 'h80, 0, 0,     0, 0, 0, 0,  0, 0, 0);
      add(1, 'hF5, 0, 0,     1, 0, 0, 0,  0, 'hF5, 0);
      add(0, 0, 0, 0,        0, 0, 0, 0,  0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive_cycle(vecs[i].v, vecs[i].d, vecs[i].rdata, vecs[i].rdy);
         check_outs($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].err,
                    vecs[i].txv, vecs[i].addr, vecs[i].wdata, vecs[i].txd);
      end

      // timeout: write command then T idle cycles
      drive_cycle(1'b1, 8'h82, 8'h00, 1'b0);
      for (int i = 1; i <= T; i++) begin
         drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);
         check_outs($sformatf("timeout_c%0d", i), 1'b0, 1'b0, (i == T), 1'b0, 4'h0, 8'h00, 8'h00);
      end
      drive_cycle(1'b1, 8'h02, 8'h00, 1'b0);
      check_outs("timeout_next_rd", 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00, 8'h00);
      drive_cycle(1'b0, 8'h00, 8'h3E, 1'b0);
      check_outs("timeout_next_resp", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h3E);
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b1);
      check_outs("timeout_next_done", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);

      // data byte arriving on the last allowed idle cycle still writes
      drive_cycle(1'b1, 8'h89, 8'h00, 1'b0);
      for (int i = 1; i < T; i++) drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);
      check_outs("edge_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
      drive_cycle(1'b1, 8'h77, 8'h00, 1'b0);
      check_outs("edge_write", 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 8'h77, 8'h00);

      // reset mid-write: asynchronous effect, then next byte is a command
      drive_cycle(1'b1, 8'h85, 8'h00, 1'b0);
      bus.i_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_values("rst_midwrite_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_cycle(1'b1, 8'h01, 8'h00, 1'b0);
      check_outs("rst_midwrite_rd", 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 8'h00, 8'h00);
      drive_cycle(1'b0, 8'h00, 8'h3C, 1'b0);
      check_outs("rst_midwrite_resp", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h3C);
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b1);

      // reset while a response is pending
      drive_cycle(1'b1, 8'h05, 8'h00, 1'b0);
      drive_cycle(1'b0, 8'h00, 8'hAB, 1'b0);
      check_outs("rst_resp_pending", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'hAB);
      rst = 1'b1;
      #1;
      check_reset_values("rst_resp_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_cycle(1'b1, 8'h8C, 8'h00, 1'b0);
      check_outs("rst_resp_cmd", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
      drive_cycle(1'b1, 8'h12, 8'h00, 1'b0);
      check_outs("rst_resp_write", 1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 8'h12, 8'h00);

      // randomized traffic against the reference model
      rst = 1'b1;
      bus.i_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_wr = 0; m_rd = 0; m_err = 0; m_txv = 0;
      m_addr = 0; m_wdata = 0; m_txd = 0;
      m_wait_addr = -1; m_idle = 0;
      for (int c = 0; c < 3000; c++) begin
         int         pv;
         bit         rv;
         bit [7:0]   rd8;
         bit [7:0]   rr;
         bit         rk;
         pv  = ((c / 300) % 2 == 1) ? 3 : 35;
         rv  = ($urandom_range(99) < pv);
         rd8 = 8'($urandom);
         if ($urandom_range(3) != 0) rd8[6:4] = 3'b000;
         rr  = 8'($urandom);
         rk  = 1'($urandom_range(1));
         model_step(rv, rd8, rr, rk);
         drive_cycle(rv, rd8, rr, rk);
         check_outs($sformatf("rand%0d", c), m_wr, m_rd, m_err, m_txv, m_addr, m_wdata, m_txd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/x_uart_cmd.md
X_UART_CMD -- requirements
Module: x_uart_cmd

Interface
REQ-001 The block SHALL have parameter p_timeout, default 2048, giving the maximum idle cycles allowed between the two bytes of a write command.
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit, a one-cycle byte strobe from the UART receiver.
REQ-005 The block SHALL have port i_data, input, 8 bits, the received byte, qualified by i_valid.
REQ-006 The block SHALL have port o_wr, output, 1 bit, a one-cycle register-write strobe.
REQ-007 The block SHALL have port o_rd, output, 1 bit, a one-cycle register-read strobe.
REQ-008 The block SHALL have port o_addr, output, 4 bits, the register address, valid with o_wr/o_rd.
REQ-009 The block SHALL have port o_wdata, output, 8 bits, the write data, valid with o_wr.
REQ-010 The block SHALL have port i_rdata, input, 8 bits, the register read data, valid combinationally in the o_rd cycle.
REQ-011 The block SHALL have port o_tx_valid, output, 1 bit, response-byte valid toward the UART transmitter.
REQ-012 The block SHALL have port o_tx_data, output, 8 bits, the response byte.
REQ-013 The block SHALL have port i_tx_ready, input, 1 bit, the transmitter accepting o_tx_data.
REQ-014 The block SHALL have port o_err, output, 1 bit, a one-cycle error strobe.

Function
REQ-015 The block SHALL decode the command byte as: bit7 = 1 write / 0 read; bits6:4 reserved and must be 0; bits3:0 address.
REQ-016 The block SHALL implement states IDLE, DATA, RD and RESP, with all outputs registered.
REQ-017 In IDLE, a valid write command at cycle N SHALL latch the address and move the block to DATA at N+1.
REQ-018 In IDLE, a valid read command at cycle N SHALL latch the address, move the block to RD and assert o_rd for exactly cycle N+1.
REQ-019 In IDLE, a command with nonzero bits6:4 SHALL pulse o_err at N+1 and leave the block in IDLE, with no o_wr or o_rd.
REQ-020 In DATA, a byte at cycle M SHALL pulse o_wr at M+1 with o_addr and o_wdata = byte, and return the block to IDLE at M+1.
REQ-021 In DATA, the timeout counter SHALL clear on entry and increment every cycle without i_valid.
REQ-022 When the counter reaches p_timeout-1 with no byte, the block SHALL return to IDLE next cycle, pulse o_err and issue no o_wr.
REQ-023 The counter SHALL saturate and never wrap.
REQ-024 In RD, the block SHALL capture i_rdata into o_tx_data, assert o_tx_valid from the next cycle and go to RESP.
REQ-025 In RESP, o_tx_valid and o_tx_data SHALL hold stable until a cycle with i_tx_ready=1; the block SHALL then deassert o_tx_valid next cycle and return to IDLE.
REQ-026 A byte arriving in RD or RESP SHALL be dropped and pulse o_err next cycle, with state and response unaffected.
REQ-027 If i_tx_ready and i_valid occur in the same RESP cycle, the handshake SHALL complete and the byte SHALL be dropped with an o_err pulse.
REQ-028 o_wr, o_rd and o_err SHALL never be high for more than one consecutive cycle per event, and o_wr and o_rd SHALL never be high together.

Reset
REQ-029 On i_rst the block SHALL enter IDLE with o_wr=0, o_rd=0, o_err=0, o_tx_valid=0, o_addr=0, o_wdata=0, o_tx_data=0 and the counter at 0, taking effect immediately and independently of i_clk.
REQ-030 Reset asserted mid-command, including while o_tx_valid=1, SHALL discard the partial command and response, and the first byte after release SHALL be treated as a command byte.

Verification
REQ-031 Write: bytes 0x83 then 0x5A -> a single o_wr pulse with o_addr=3, o_wdata=0x5A, one cycle after the 0x5A strobe; no o_err.
REQ-032 Read: byte 0x07 with i_rdata=0xC3 and i_tx_ready held 0 for 5 cycles, then 1 -> o_rd pulse with o_addr=7; o_tx_valid=1 with o_tx_data=0xC3 stable for 6 cycles; o_tx_valid low the cycle after the handshake.
REQ-033 Reserved bits: byte 0x95 -> o_err pulse, no o_wr/o_rd; a following 0x81, 0x11 -> normal write of 0x11 to address 1.
REQ-034 Timeout with p_timeout=16: byte 0x82, then no strobe for 16 cycles -> o_err pulse, no o_wr; a next byte 0x02 -> o_rd with address 2.
REQ-035 Busy drop: byte 0x04, then byte 0xFF while o_tx_valid=1 -> o_err pulse, o_tx_data unchanged, exactly one response.
REQ-036 Reset mid-write: byte 0x85, i_rst pulse, then byte 0x01 -> 0x01 decoded as a read of address 1, no o_wr.
